// File: rtl/seq_divider_pkg.sv
// Shared definitions for the multdiv sequential divider: FSM encoding,
// default operand width and the most-negative constant helper.
package seq_divider_pkg;

    localparam int DIV_WIDTH = 32;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } div_state_e;

    // Two's-complement most-negative value for widths up to 64 bits;
    // callers slice the low w bits.
    function automatic logic [63:0] most_neg(input int unsigned w);
        most_neg = 64'd1 << (w - 1);
    endfunction

endpackage

// File: rtl/seq_divider_div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder and subtract the divisor when it fits.
module div_step
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic             dvd_bit_i,
    input  logic [WIDTH-1:0] dvs_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             q_bit_o
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // The shifted remainder is kept one bit wider so divisors above
    // 2^(WIDTH-1) still compare correctly; the result always fits WIDTH bits.
    always_comb begin
        shifted = {rem_i, dvd_bit_i};
        diff    = shifted - {1'b0, dvs_i};
        q_bit_o = ~diff[WIDTH];
        rem_o   = q_bit_o ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider, one quotient bit per clock, signed or
// unsigned per operation, behind the ctrl_DIV / inputRDY / resultRDY handshake.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             ctrl_DIV,
    input  logic             ctrl_signed,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic [WIDTH-1:0] data_remainder,
    output logic             data_exception,
    output logic             data_overflow,
    output logic             data_inputRDY,
    output logic             data_resultRDY
);

    // Handshake: ctrl_DIV is accepted on a rising edge only while
    // data_inputRDY=1 (IDLE or DONE); data_resultRDY is high for the single
    // DONE cycle and the result outputs stay valid until the next result.

    localparam logic [63:0]      MOST_NEG_64 = most_neg(WIDTH);
    localparam logic [WIDTH-1:0] MOST_NEG    = MOST_NEG_64[WIDTH-1:0];
    localparam logic [CNT_W-1:0] CNT_INIT    = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             prep_q, prep_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             a_neg_q, a_neg_d;
    logic             b_neg_q, b_neg_d;
    logic             dbz_q, dbz_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             exc_q, exc_d;
    logic             ovfl_q, ovfl_d;

    logic [WIDTH-1:0] step_rem;
    logic             step_qbit;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i     (rem_q),
        .dvd_bit_i (dvd_q[WIDTH-1]),
        .dvs_i     (dvs_q),
        .rem_o     (step_rem),
        .q_bit_o   (step_qbit)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        prep_d      = prep_q;
        dvd_d       = dvd_q;
        dvs_d       = dvs_q;
        rem_d       = rem_q;
        a_neg_d     = a_neg_q;
        b_neg_d     = b_neg_q;
        dbz_d       = dbz_q;
        ovf_d       = ovf_q;
        result_d    = result_q;
        remainder_d = remainder_q;
        exc_d       = exc_q;
        ovfl_d      = ovfl_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (ctrl_DIV) begin
                    dvd_d   = data_operandA;
                    dvs_d   = data_operandB;
                    rem_d   = '0;
                    a_neg_d = ctrl_signed & data_operandA[WIDTH-1];
                    b_neg_d = ctrl_signed & data_operandB[WIDTH-1];
                    dbz_d   = (data_operandB == '0);
                    ovf_d   = ctrl_signed && (data_operandA == MOST_NEG) &&
                              (data_operandB == '1);
                    cnt_d   = CNT_INIT;
                    prep_d  = 1'b1;
                    state_d = (data_operandB == '0) ? S_FIX : S_CALC;
                end
            end

            S_CALC: begin
                // First CALC cycle turns the raw operands into magnitudes,
                // keeping the negators off the input path.
                if (prep_q) begin
                    prep_d = 1'b0;
                    dvd_d  = a_neg_q ? -dvd_q : dvd_q;
                    dvs_d  = b_neg_q ? -dvs_q : dvs_q;
                end else begin
                    rem_d = step_rem;
                    dvd_d = {dvd_q[WIDTH-2:0], step_qbit};
                    cnt_d = cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        state_d = S_FIX;
                    end
                end
            end

            S_FIX: begin
                if (dbz_q) begin
                    result_d    = '1;
                    remainder_d = dvd_q;
                    exc_d       = 1'b1;
                    ovfl_d      = 1'b0;
                end else begin
                    result_d    = (a_neg_q ^ b_neg_q) ? -dvd_q : dvd_q;
                    remainder_d = a_neg_q ? -rem_q : rem_q;
                    exc_d       = 1'b0;
                    ovfl_d      = ovf_q;
                end
                state_d = S_DONE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            prep_q      <= 1'b0;
            dvd_q       <= '0;
            dvs_q       <= '0;
            rem_q       <= '0;
            a_neg_q     <= 1'b0;
            b_neg_q     <= 1'b0;
            dbz_q       <= 1'b0;
            ovf_q       <= 1'b0;
            result_q    <= '0;
            remainder_q <= '0;
            exc_q       <= 1'b0;
            ovfl_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            prep_q      <= prep_d;
            dvd_q       <= dvd_d;
            dvs_q       <= dvs_d;
            rem_q       <= rem_d;
            a_neg_q     <= a_neg_d;
            b_neg_q     <= b_neg_d;
            dbz_q       <= dbz_d;
            ovf_q       <= ovf_d;
            result_q    <= result_d;
            remainder_q <= remainder_d;
            exc_q       <= exc_d;
            ovfl_q      <= ovfl_d;
        end
    end

    assign data_result    = result_q;
    assign data_remainder = remainder_q;
    assign data_exception = exc_q;
    assign data_overflow  = ovfl_q;
    assign data_inputRDY  = (state_q == S_IDLE) || (state_q == S_DONE);
    assign data_resultRDY = (state_q == S_DONE);

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: directed and random divisions against an
// arithmetic reference model, plus reset-abort and back-to-back cases.
module tb_seq_divider;

    localparam int W = 32;

    logic         clock;
    logic         resetn;
    logic         ctrl_DIV;
    logic         ctrl_signed;
    logic [W-1:0] data_operandA;
    logic [W-1:0] data_operandB;
    logic [W-1:0] data_result;
    logic [W-1:0] data_remainder;
    logic         data_exception;
    logic         data_overflow;
    logic         data_inputRDY;
    logic         data_resultRDY;

    int checks = 0;
    int errors = 0;

    // {exception, overflow, remainder, quotient}
    logic [2*W+1:0] exp_q[$];

    seq_divider #(.WIDTH(W)) dut (
        .clock          (clock),
        .resetn         (resetn),
        .ctrl_DIV       (ctrl_DIV),
        .ctrl_signed    (ctrl_signed),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_remainder (data_remainder),
        .data_exception (data_exception),
        .data_overflow  (data_overflow),
        .data_inputRDY  (data_inputRDY),
        .data_resultRDY (data_resultRDY)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [2*W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic s);
        longint sa, sb, q, r;
        logic   ovf;
        logic [W-1:0] qw, rw;
        if (b == '0) begin
            return {1'b1, 1'b0, a, {W{1'b1}}};
        end
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'(a);
            sb = longint'(b);
        end
        q   = sa / sb;
        r   = sa % sb;
        ovf = s && (sa == -(longint'(1) <<< (W - 1))) && (sb == -1);
        qw  = q[W-1:0];
        rw  = r[W-1:0];
        return {1'b0, ovf, rw, qw};
    endfunction

    // Called at a negedge with inputRDY high; returns just after edge 0.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        ctrl_DIV      = 1'b1;
        ctrl_signed   = s;
        data_operandA = a;
        data_operandB = b;
        exp_q.push_back(model(a, b, s));
        @(posedge clock);
        #1;
        ctrl_DIV      = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
        ctrl_signed   = 1'($urandom_range(0, 1));
    endtask

    // Counts edges from acceptance to the resultRDY cycle, optionally poking
    // ctrl_DIV while busy, then scores the outputs. Ends at the DONE negedge.
    task automatic wait_result(input string tag, input int exp_lat, input bit poke);
        int k;
        logic [2*W+1:0] e;
        k = 0;
        @(negedge clock);
        while (!data_resultRDY && k < 200) begin
            if (poke && k == 5) begin
                ctrl_DIV      = 1'b1;
                data_operandB = '0;
            end else begin
                ctrl_DIV = 1'b0;
            end
            @(negedge clock);
            k++;
        end
        ctrl_DIV = 1'b0;
        check({tag, " latency"}, W'(k), W'(exp_lat));
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        check({tag, " result"}, data_result, e[W-1:0]);
        check({tag, " remainder"}, data_remainder, e[2*W-1:W]);
        check({tag, " exception"}, W'(data_exception), W'(e[2*W+1]));
        check({tag, " overflow"}, W'(data_overflow), W'(e[2*W]));
        check({tag, " inputRDY in done"}, W'(data_inputRDY), W'(1));
    endtask

    task automatic div_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic s, input bit poke);
        issue(a, b, s);
        wait_result(tag, (b == '0) ? 1 : W + 2, poke);
        @(negedge clock);
        check({tag, " pulse width"}, W'(data_resultRDY), W'(0));
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " result"}, data_result, '0);
        check({tag, " remainder"}, data_remainder, '0);
        check({tag, " exception"}, W'(data_exception), W'(0));
        check({tag, " overflow"}, W'(data_overflow), W'(0));
        check({tag, " resultRDY"}, W'(data_resultRDY), W'(0));
        check({tag, " inputRDY"}, W'(data_inputRDY), W'(1));
    endtask

    initial begin
        logic [W-1:0] a, b;
        logic         s;
        int           pulses;

        resetn        = 1'b0;
        ctrl_DIV      = 1'b0;
        ctrl_signed   = 1'b0;
        data_operandA = '0;
        data_operandB = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check_reset_state("reset");
        resetn = 1'b1;
        @(negedge clock);

        div_op("u 100/7", 32'd100, 32'd7, 1'b0, 1'b1);
        div_op("s -100/7", -32'sd100, 32'd7, 1'b1, 1'b0);
        div_op("s 100/-7", 32'd100, -32'sd7, 1'b1, 1'b1);
        div_op("u ffffffff/2", 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0);
        div_op("s ffffffff/2", 32'hFFFF_FFFF, 32'd2, 1'b1, 1'b0);
        div_op("dbz 1234/0", 32'd1234, 32'd0, 1'b0, 1'b0);
        div_op("s ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1);
        div_op("u big divisor", 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 1'b0);
        div_op("s mostneg/1", 32'h8000_0000, 32'd1, 1'b1, 1'b0);

        for (int i = 0; i < 24; i++) begin
            s = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 5))
                0: b = '0;
                1: b = W'($urandom_range(1, 15));
                2: b = -W'($urandom_range(1, 15));
                3: b = '1;
                default: b = $urandom;
            endcase
            case ($urandom_range(0, 3))
                0: a = 32'h8000_0000;
                1: a = W'($urandom_range(0, 1000));
                default: a = $urandom;
            endcase
            div_op("random", a, b, s, 1'($urandom_range(0, 1)));
        end

        // Abort in the middle of CALC: no result may follow.
        issue(32'd5000, 32'd3, 1'b0);
        repeat (10) @(negedge clock);
        resetn = 1'b0;
        @(negedge clock);
        check_reset_state("mid-op reset");
        exp_q.delete();
        resetn = 1'b1;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (data_resultRDY) pulses++;
        end
        check("no pulse after abort", W'(pulses), W'(0));

        // Back-to-back: second start issued in the DONE cycle of the first.
        issue(32'd20, 32'd3, 1'b0);
        wait_result("b2b first 20/3", W + 2, 1'b0);
        issue(32'd9, 32'd4, 1'b0);
        wait_result("b2b second 9/4", W + 2, 1'b0);
        @(negedge clock);
        check("b2b pulse width", W'(data_resultRDY), W'(0));
        check("b2b hold result", data_result, 32'd2);
        check("b2b hold remainder", data_remainder, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
